// File: rtl/regfile_np.sv
// regfile_np -- parametrised multi-read-port register file.
//
// It has one write port with byte enables and N_RD independent read ports.
// Each read port returns its data one cycle after the address is presented.
// A hardware sweep zeroes the whole array after reset and after each
// clear_req. The storage array itself has no reset.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   rd_en      [N_RD]          per-port read enable
//   rd_addr    [N_RD*ADDR_W]   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    [N_RD*DATA_W]   packed registered read data, port i at [i*DATA_W +: DATA_W]
//   we         write enable
//   wr_addr    [ADDR_W]        write address
//   wr_data    [DATA_W]        write data
//   wr_be      [DATA_W/8]      byte enables, bit k enables byte k
//   clear_req  one-cycle pulse that requests a full clear sweep
//   ready      high when the array is valid and accepting writes
module regfile_np #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_RD-1:0]          rd_en,
  input  logic [N_RD*ADDR_W-1:0]   rd_addr,
  output logic [N_RD*DATA_W-1:0]   rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     clear_req,
  output logic                     ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        clr_ptr_q, clr_ptr_d;
  logic [N_RD*DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [DATA_W-1:0]        mem [DEPTH];

  logic                     wr_fire;
  logic [DATA_W-1:0]        wr_old;
  logic [DATA_W-1:0]        wr_merged;
  logic [ADDR_W-1:0]        ra;
  logic [DATA_W-1:0]        rv;

  assign ready   = (state_q == RUN);
  assign rd_data = rd_data_q;

  // A write commits only in RUN. It is dropped when clear_req is high in the
  // same cycle, and a write to entry 0 is dropped when ZERO_REG is set.
  assign wr_fire = (state_q == RUN) && we && !clear_req &&
                   !((ZERO_REG != 0) && (wr_addr == '0));

  // This is the post-write word. The array stores it, and a bypassed read
  // returns the same word.
  always_comb begin
    wr_old    = mem[wr_addr];
    wr_merged = wr_old;
    for (int unsigned k = 0; k < NB; k++) begin
      if (wr_be[k]) wr_merged[k*8 +: 8] = wr_data[k*8 +: 8];
    end
  end

  // State machine and clear pointer.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        // The pointer wraps to 0 on the last entry, so the next sweep
        // starts at entry 0.
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) state_d = RUN;
      end
      RUN: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // Read ports. Zero-register masking is applied after bypass, so entry 0
  // still reads 0 even if a write to it is in flight.
  always_comb begin
    rd_data_d = rd_data_q;
    ra        = '0;
    rv        = '0;
    if (state_q == CLEAR) begin
      rd_data_d = '0;
    end else begin
      for (int unsigned i = 0; i < N_RD; i++) begin
        if (rd_en[i]) begin
          ra = rd_addr[i*ADDR_W +: ADDR_W];
          rv = mem[ra];
          if ((BYPASS != 0) && wr_fire && (wr_addr == ra)) rv = wr_merged;
          if ((ZERO_REG != 0) && (ra == '0)) rv = '0;
          rd_data_d[i*DATA_W +: DATA_W] = rv;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // The storage array has no reset. The clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem[clr_ptr_q] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_merged;
    end
  end

endmodule

// File: tb/tb_regfile_np.sv
module tb_regfile_np;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        clear_req;

  logic [63:0] rd_data_a, rd_data_b;
  logic        ready_a, ready_b;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  // Default parameters: ZERO_REG = 1, BYPASS = 1.
  regfile_np #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clear_req(clear_req), .ready(ready_a)
  );

  // Alternate build: no zero register, no bypass. It gets the same stimulus.
  regfile_np #(.DATA_W(32), .ADDR_W(5), .N_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .clear_req(clear_req), .ready(ready_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks both ports of both DUTs. ea is the expected value for u_a and
  // eb is the expected value for u_b.
  task automatic chk_rd(input string tag, input logic [31:0] ea0, input logic [31:0] ea1,
                        input logic [31:0] eb0, input logic [31:0] eb1);
    chk({tag, ".a0"}, rd_data_a[31:0],  ea0);
    chk({tag, ".a1"}, rd_data_a[63:32], ea1);
    chk({tag, ".b0"}, rd_data_b[31:0],  eb0);
    chk({tag, ".b1"}, rd_data_b[63:32], eb1);
  endtask

  task automatic chk_ready(input string tag, input logic exp);
    chk({tag, ".rdy_a"}, {31'd0, ready_a}, {31'd0, exp});
    chk({tag, ".rdy_b"}, {31'd0, ready_b}, {31'd0, exp});
  endtask

  // One rising edge. Outputs are then sampled on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    rd_en = 2'b00; we = 1'b0; wr_be = 4'h0; clear_req = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a0, input logic [4:0] a1);
    rd_en = 2'b11; rd_addr = {a1, a0};
    tick();
    rd_en = 2'b00;
  endtask

  initial begin
    #50000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    idle();
    #12;
    chk_ready("reset", 1'b0);
    chk_rd("reset", 0, 0, 0, 0);

    // Release reset away from the clock edge. ready rises only after the
    // 32nd edge. rd_en is held high, but rd_data must stay 0 during the sweep.
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 2'b11; rd_addr = {5'd9, 5'd1};
    for (int e = 1; e <= 32; e++) begin
      tick();
      chk_ready($sformatf("init_sweep%0d", e), (e == 32));
      if (e == 16) chk_rd("init_sweep_rd", 0, 0, 0, 0);
    end
    rd_en = 2'b00;

    // After the initial sweep, every address reads 0.
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), 5'(31 - a));
      chk_rd($sformatf("zero%0d", a), 0, 0, 0, 0);
    end

    // Full-word write to address 1, then read it on both ports.
    do_write(5'd1, 32'hA5A5A5A5, 4'hF);
    do_read(5'd1, 5'd1);
    chk_rd("wr1", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // rd_en low: the outputs hold even though the address changes.
    rd_addr = {5'd0, 5'd0};
    tick();
    chk_rd("hold", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

    // Byte-enable write while port 0 reads the same address. u_a forwards
    // the merged word. u_b returns the old contents.
    do_write(5'd3, 32'h11223344, 4'hF);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hAABBCCDD; wr_be = 4'h5;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    tick();
    idle();
    chk_rd("bypass", 32'h11BB33DD, 32'hA5A5A5A5, 32'h11223344, 32'hA5A5A5A5);
    do_read(5'd3, 5'd3);
    chk_rd("merged", 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    // Write to address 0. The zero register (u_a) discards the write.
    do_write(5'd0, 32'hFFFFFFFF, 4'hF);
    do_read(5'd0, 5'd0);
    chk_rd("zreg", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Write to address 0 while reading it in the same cycle. u_a still
    // reads 0. u_b (no bypass) returns the pre-write value.
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; wr_be = 4'hF;
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    tick();
    idle();
    chk_rd("zreg_byp", 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Fill addresses 1..4, then pulse clear_req together with a write to
    // address 5. The write is dropped.
    for (int a = 1; a <= 4; a++) do_write(5'(a), 32'hC0DE0000 + 32'(a), 4'hF);
    do_read(5'd4, 5'd2);
    chk_rd("fill", 32'hC0DE0004, 32'hC0DE0002, 32'hC0DE0004, 32'hC0DE0002);
    chk_ready("pre_clr", 1'b1);
    clear_req = 1'b1; we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
    tick();
    idle();
    chk_ready("clr_edge", 1'b0);
    rd_en = 2'b11; rd_addr = {5'd4, 5'd1};
    for (int e = 1; e <= 32; e++) begin
      // A clear_req during the sweep is ignored, and so is a write to an
      // entry the sweep has already cleared.
      if (e == 5) begin
        clear_req = 1'b1; we = 1'b1; wr_addr = 5'd2; wr_data = 32'h55AA55AA; wr_be = 4'hF;
      end
      tick();
      clear_req = 1'b0; we = 1'b0;
      chk_ready($sformatf("clr_sweep%0d", e), (e == 32));
      if (e == 1 || e == 20) chk_rd($sformatf("clr_rd%0d", e), 0, 0, 0, 0);
    end
    rd_en = 2'b00;
    for (int a = 1; a <= 5; a++) begin
      do_read(5'(a), 5'(a));
      chk_rd($sformatf("cleared%0d", a), 0, 0, 0, 0);
    end

    // Reset during RUN clears rd_data and ready asynchronously.
    do_write(5'd7, 32'h13579BDF, 4'hF);
    do_read(5'd7, 5'd7);
    chk_rd("pre_rst", 32'h13579BDF, 32'h13579BDF, 32'h13579BDF, 32'h13579BDF);
    #2 rst_n = 1'b0;
    #1;
    chk_ready("run_rst", 1'b0);
    chk_rd("run_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset at sweep edge 10. The sweep restarts from 0, so ready returns
    // only after 32 further edges.
    for (int e = 1; e <= 10; e++) tick();
    chk_ready("sweep10", 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_ready("sweep_rst", 1'b0);
    chk_rd("sweep_rst", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      if (e >= 22) chk_ready($sformatf("restart%0d", e), (e == 32));
    end
    do_read(5'd7, 5'd3);
    chk_rd("post_restart", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
